// File: rtl/reg_file_sb.sv
// reg_file_sb -- multi-port register file with a per-register busy scoreboard.
//
// Two combinational read ports (R_Bus / S_Bus) and two synchronous write
// ports. Decode reserves a destination register (marks it busy); writeback
// writes the result and clears busy. Optional same-cycle write-to-read
// bypass and an optional hard-wired zero register.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   rd1_addr/data/busy    read port 1: address in, data and busy out
//   rd2_addr/data/busy    read port 2: address in, data and busy out
//   wr1_en/addr/data      write port 1
//   wr2_en/addr/data      write port 2 (wins over wr1 on an address collision)
//   rsv_en/addr, rsv_ok   reserve request; rsv_ok = request would be accepted
module reg_file_sb #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int ZERO_REG   = 0,
   parameter int BYPASS     = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] rd1_addr,
   output logic [DATA_WIDTH-1:0] rd1_data,
   output logic                  rd1_busy,
   input  logic [ADDR_WIDTH-1:0] rd2_addr,
   output logic [DATA_WIDTH-1:0] rd2_data,
   output logic                  rd2_busy,
   input  logic                  wr1_en,
   input  logic [ADDR_WIDTH-1:0] wr1_addr,
   input  logic [DATA_WIDTH-1:0] wr1_data,
   input  logic                  wr2_en,
   input  logic [ADDR_WIDTH-1:0] wr2_addr,
   input  logic [DATA_WIDTH-1:0] wr2_data,
   input  logic                  rsv_en,
   input  logic [ADDR_WIDTH-1:0] rsv_addr,
   output logic                  rsv_ok
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0]      busy;
   logic                  wr1_do;
   logic                  wr2_do;
   logic                  rsv_do;

   // True when the address targets the hard-wired zero register.
   function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   // Writes that actually land: zero-register writes are discarded and
   // wr1 is dropped when wr2 targets the same register.
   assign wr2_do = wr2_en && !is_zero(wr2_addr);
   assign wr1_do = wr1_en && !is_zero(wr1_addr) &&
                   !(wr2_do && (wr2_addr == wr1_addr));

   // Reserve acceptance looks at registered busy only, so a write to the
   // same register this cycle cannot unblock a reserve until next cycle.
   assign rsv_ok = rst_n && (is_zero(rsv_addr) || !busy[rsv_addr]);
   assign rsv_do = rsv_en && rsv_ok && !is_zero(rsv_addr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         busy <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr2_do && (wr2_addr == ADDR_WIDTH'(i)))
               regs[i] <= wr2_data;
            else if (wr1_do && (wr1_addr == ADDR_WIDTH'(i)))
               regs[i] <= wr1_data;
         end
         // Writes clear busy; an accepted reserve is applied last so it
         // wins over a write to the same register.
         if (wr1_do) busy[wr1_addr] <= 1'b0;
         if (wr2_do) busy[wr2_addr] <= 1'b0;
         if (rsv_do) busy[rsv_addr] <= 1'b1;
      end
   end

   // Read ports: forced to zero/not-busy during reset and for the zero
   // register; otherwise bypass (wr2 priority) or the stored value.
   for (genvar p = 0; p < 2; p++) begin : g_rd
      logic [ADDR_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] d;
      logic                  b;

      assign a = (p == 0) ? rd1_addr : rd2_addr;

      always_comb begin
         d = '0;
         b = 1'b0;
         if (rst_n && !is_zero(a)) begin
            if ((BYPASS != 0) && wr2_do && (wr2_addr == a)) begin
               d = wr2_data;
            end else if ((BYPASS != 0) && wr1_do && (wr1_addr == a)) begin
               d = wr1_data;
            end else begin
               d = regs[a];
               b = busy[a];
            end
         end
      end
   end

   assign rd1_data = g_rd[0].d;
   assign rd1_busy = g_rd[0].b;
   assign rd2_data = g_rd[1].d;
   assign rd2_busy = g_rd[1].b;

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-port CPU register file with an integrated busy scoreboard. It provides two asynchronous read ports and two synchronous write ports, with optional same-cycle write-to-read bypass and an optional hard-wired zero register. A per-register busy bit supports pipeline hazard detection between the decode stage (reserve) and writeback (write). It replaces the fixed 16x16 register file in the CPU datapath; the read ports drive R_Bus and S_Bus.

## Interface

Parameters:
- DATA_WIDTH, 16, register width in bits
- ADDR_WIDTH, 4, address width; depth = 2^ADDR_WIDTH
- ZERO_REG, 0, when 1: register 0 always reads 0, ignores writes, and is never busy
- BYPASS, 1, when 1: a write in the current cycle is forwarded to a matching read port in the same cycle

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd1_addr  in  ADDR_WIDTH  read port 1 address (R_Bus)
- rd1_data  out  DATA_WIDTH  read port 1 data
- rd1_busy  out  1  register at rd1_addr has a pending result
- rd2_addr  in  ADDR_WIDTH  read port 2 address (S_Bus)
- rd2_data  out  DATA_WIDTH  read port 2 data
- rd2_busy  out  1  register at rd2_addr has a pending result
- wr1_en  in  1  write port 1 enable
- wr1_addr  in  ADDR_WIDTH  write port 1 address
- wr1_data  in  DATA_WIDTH  write port 1 data
- wr2_en  in  1  write port 2 enable
- wr2_addr  in  ADDR_WIDTH  write port 2 address
- wr2_data  in  DATA_WIDTH  write port 2 data
- rsv_en  in  1  reserve request: mark rsv_addr busy
- rsv_addr  in  ADDR_WIDTH  register to reserve
- rsv_ok  out  1  reserve will be accepted this cycle

## Operation

- Reset (rst_n low): all registers cleared to 0 and all busy bits cleared asynchronously. While rst_n is low: rd*_data = 0, rd*_busy = 0, rsv_ok = 0, bypass disabled, and all writes and reserves are ignored.
- Read: rdN_data = regs[rdN_addr], combinational. With ZERO_REG=1 and address 0, the output is 0.
- Write: on a rising edge with wrN_en=1, regs[wrN_addr] <= wrN_data.
- Write collision: if both ports are enabled to the same address, wr2 wins and wr1 is dropped.
- Zero register: with ZERO_REG=1, writes to address 0 are discarded and never bypassed.
- Bypass (BYPASS=1): if rdN_addr equals an enabled, non-discarded write address in the same cycle, rdN_data = that write data (wr2 priority) and rdN_busy = 0.
- Busy state: one bit per register.
- rsv_ok = !busy[rsv_addr]. With ZERO_REG=1 and address 0, rsv_ok is always 1.
- Accepted reserve (rsv_en && rsv_ok): busy[rsv_addr] <= 1 at the next edge. With ZERO_REG=1 and address 0, busy is not set.
- Rejected reserve (rsv_en && !rsv_ok): no state change; the requester must stall and retry.
- Write clears busy: any performed write clears busy[wrN_addr] at the edge.
- Simultaneous reserve and write to the same address: the write data is stored and busy ends at 1 (reserve wins).
- rsv_ok is computed from registered busy only. A write to rsv_addr in the same cycle does not make rsv_ok 1 until the next cycle.

## Timing

- Read latency: 0 cycles (combinational from address).
- Write visibility: next cycle without bypass; same cycle with BYPASS=1.
- Reserve to rdN_busy=1: visible the cycle after acceptance.
- Write to rdN_busy=0: same cycle with bypass; next cycle without.
- No internal pipelining; all state updates occur on one edge.
- Asynchronous reset assertion takes effect immediately, including mid-write.
- Reset deassertion is synchronised externally. The first edge after deassertion may write or reserve.

## Test plan

- Reset: write 0xBEEF to r3, assert rst_n low mid-cycle -> rd1_data(r3)=0 and rd1_busy=0 immediately; after release r3 still reads 0.
- Write collision: wr1 (r5, 0x1111) and wr2 (r5, 0x2222) in the same cycle -> r5 reads 0x2222 next cycle. With BYPASS=1, rd1_addr=5 shows 0x2222 in the same cycle.
- Bypass off: BYPASS=0, write r7=0x00A5 with rd2_addr=7 (old value 0) -> rd2_data=0 this cycle, 0x00A5 next cycle.
- Scoreboard, reserve path: reserve r2 -> rsv_ok=1, and rd1_busy=1 the next cycle. A second reserve of r2 gives rsv_ok=0 and busy stays 1.
- Scoreboard, write path: write r2=0x0042 -> busy clears (same cycle via bypass when BYPASS=1).
- Reserve and write together: reserve r4 and write r4=0x0F0F in the same cycle, r4 already busy -> r4 reads 0x0F0F; rsv_ok=0 in that cycle, so busy ends 0 (write clears). Repeat with r4 not busy -> r4 holds 0x0F0F and busy ends 1.
- Zero register: ZERO_REG=1, write r0=0xFFFF and reserve r0 -> rd1_data=0, rd1_busy=0, rsv_ok=1 throughout.
